iq_mod: RTL and testbench

//  Transmit-side quadrature modulator, the inverse of the receive demodulator.

---
 rtl/demod_pkg.sv | 44 ++++
 rtl/iq_mod_if.sv | 17 +
 rtl/carrier_nco.sv | 41 ++++
 rtl/iq_mod.sv | 146 ++++++++++++++
 tb/tb_iq_mod.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/demod_pkg.sv
// demod_pkg: constants, types and carrier tables shared by the quadrature
// modulator (iq_mod) and the receive-side demodulator.
//   DATA_W      sample / LUT / output width
//   CH_W        channel index width
//   LUT_LEN     carrier period in samples
//   SINE_LUT_*  5-point carrier, Q1.23 signed
//   state_e     one-hot modulator FSM state
//   phase_next  per-channel phase increment with wrap at LUT_LEN
package demod_pkg;

  localparam int unsigned DATA_W  = 24;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned NUM_CH  = 1 << CH_W;
  localparam int unsigned LUT_LEN = 5;
  localparam int unsigned PHASE_W = $clog2(LUT_LEN);
  localparam int unsigned PROD_W  = 2 * DATA_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [PROD_W:0]   sum_t;
  typedef logic [PHASE_W-1:0]       phase_t;

  localparam phase_t PHASE_LAST = PHASE_W'(LUT_LEN - 1);

  localparam sample_t SINE_LUT_I [LUT_LEN] = '{
    24'sd0, 24'sd7978039, 24'sd4930699, -24'sd4930701, -24'sd7978041
  };
  localparam sample_t SINE_LUT_Q [LUT_LEN] = '{
    24'sd8388607, 24'sd2592221, -24'sd6786527, -24'sd6786527, 24'sd2592221
  };

  typedef enum logic [4:0] {
    StReadI = 5'b00001,
    StReadQ = 5'b00010,
    StMul   = 5'b00100,
    StSum   = 5'b01000,
    StTx    = 5'b10000
  } state_e;

  function automatic phase_t phase_next(input phase_t p);
    return (p == PHASE_LAST) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/iq_mod_if.sv
// iq_mod_if: AXI-Stream style beat bundle (tdata/tvalid/tready/tuser).
//   master modport drives tdata/tvalid/tuser and samples tready.
//   slave  modport samples tdata/tvalid/tuser and drives tready.
interface iq_mod_if #(
  parameter int unsigned DataW = 24,
  parameter int unsigned UserW = 2
) ();

  logic [DataW-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic [UserW-1:0] tuser;

  modport master (output tdata, output tvalid, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tuser, output tready);

endinterface

// File: rtl/carrier_nco.sv
// carrier_nco: per-channel carrier phase registers with wrap at LUT_LEN and
// combinational read of the I/Q carrier LUT at the selected channel's phase.
//   clk_i     clock
//   rst_i     synchronous active-high reset, clears every phase to 0
//   ch_i      channel whose phase is read and (optionally) advanced
//   adv_i     advance phase[ch_i] by one step this cycle
//   lut_i_o   SINE_LUT_I[phase[ch_i]]
//   lut_q_o   SINE_LUT_Q[phase[ch_i]]
module carrier_nco
  import demod_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [CH_W-1:0] ch_i,
  input  logic            adv_i,
  output sample_t         lut_i_o,
  output sample_t         lut_q_o
);

  phase_t phase_q [NUM_CH];
  phase_t phase_d [NUM_CH];

  always_comb begin
    phase_d = phase_q;
    if (adv_i) begin
      phase_d[ch_i] = phase_next(phase_q[ch_i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '{default: '0};
    end else begin
      phase_q <= phase_d;
    end
  end

  assign lut_i_o = SINE_LUT_I[phase_q[ch_i]];
  assign lut_q_o = SINE_LUT_Q[phase_q[ch_i]];

endmodule

// File: rtl/iq_mod.sv
// iq_mod: transmit-side quadrature modulator. Pairs interleaved I/Q beats per
// channel and emits y = (I*LUT_I[p] + Q*LUT_Q[p]) >>> 24, one real sample per pair.
//   s_axis_aclk    clock
//   s_axis_areset  synchronous active-high reset
//   s_axis         input beats: tdata = signed I or Q, tuser = {is_q, channel}
//   m_axis         output samples: tdata = signed sample, tuser = channel
//   err_seq        1-cycle pulse on an I/Q sequencing violation
module iq_mod
  import demod_pkg::*;
(
  input  logic     s_axis_aclk,
  input  logic     s_axis_areset,
  iq_mod_if.slave  s_axis,
  iq_mod_if.master m_axis,
  output logic     err_seq
);

  state_e          state_q, state_d;
  sample_t         i_q, i_d;
  sample_t         q_q, q_d;
  logic [CH_W-1:0] ch_q, ch_d;
  prod_t           prod_i_q, prod_i_d;
  prod_t           prod_q_q, prod_q_d;
  sample_t         tdata_q, tdata_d;
  logic [CH_W-1:0] tuser_q, tuser_d;
  logic            err_q, err_d;

  logic            s_ready;
  logic            in_hs;
  logic            beat_is_q;
  logic [CH_W-1:0] beat_ch;
  logic            adv;
  sample_t         lut_i, lut_q;
  sum_t            sum_full;
  logic            unused_sum_msb;

  carrier_nco u_nco (
    .clk_i   (s_axis_aclk),
    .rst_i   (s_axis_areset),
    .ch_i    (ch_q),
    .adv_i   (adv),
    .lut_i_o (lut_i),
    .lut_q_o (lut_q)
  );

  assign s_ready   = (state_q == StReadI || state_q == StReadQ) && !s_axis_areset;
  assign in_hs     = s_axis.tvalid && s_ready;
  assign beat_is_q = s_axis.tuser[CH_W];
  assign beat_ch   = s_axis.tuser[CH_W-1:0];

  // The sum of the two products never exceeds 24 significant bits after the
  // shift (|LUT_I|+|LUT_Q| < 2^24), so bits [47:24] are the floored result and
  // the extra sign bit is redundant.
  assign sum_full       = sum_t'(prod_i_q) + sum_t'(prod_q_q);
  assign unused_sum_msb = sum_full[PROD_W];

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    q_d      = q_q;
    ch_d     = ch_q;
    prod_i_d = prod_i_q;
    prod_q_d = prod_q_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    err_d    = 1'b0;
    adv      = 1'b0;
    unique case (state_q)
      StReadI: begin
        if (in_hs) begin
          if (beat_is_q) begin
            err_d = 1'b1;
          end else begin
            i_d     = $signed(s_axis.tdata);
            ch_d    = beat_ch;
            state_d = StReadQ;
          end
        end
      end
      StReadQ: begin
        if (in_hs) begin
          if (!beat_is_q) begin
            // Resync on a fresh I: it replaces the pending one.
            i_d   = $signed(s_axis.tdata);
            ch_d  = beat_ch;
            err_d = 1'b1;
          end else if (beat_ch == ch_q) begin
            q_d     = $signed(s_axis.tdata);
            state_d = StMul;
          end else begin
            err_d   = 1'b1;
            state_d = StReadI;
          end
        end
      end
      StMul: begin
        prod_i_d = prod_t'(i_q) * prod_t'(lut_i);
        prod_q_d = prod_t'(q_q) * prod_t'(lut_q);
        state_d  = StSum;
      end
      StSum: begin
        tdata_d = sum_full[DATA_W +: DATA_W];
        tuser_d = ch_q;
        state_d = StTx;
      end
      StTx: begin
        if (m_axis.tready) begin
          adv     = 1'b1;
          state_d = StReadI;
        end
      end
      default: state_d = StReadI;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q  <= StReadI;
      i_q      <= '0;
      q_q      <= '0;
      ch_q     <= '0;
      prod_i_q <= '0;
      prod_q_q <= '0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      q_q      <= q_d;
      ch_q     <= ch_d;
      prod_i_q <= prod_i_d;
      prod_q_q <= prod_q_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      err_q    <= err_d;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = (state_q == StTx);
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tuser  = tuser_q;
  assign err_seq       = err_q;

endmodule

// File: tb/tb_iq_mod.sv
// tb_iq_mod: directed self-checking bench for iq_mod. Drives I/Q beats on the
// slave stream and checks samples, latency, back-pressure, sequencing errors
// and reset against hand-computed values.
module tb_iq_mod;

  logic clk;
  logic rst;
  logic err_seq;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   idle_cnt;

  iq_mod_if #(.DataW(24), .UserW(3)) s_if ();
  iq_mod_if #(.DataW(24), .UserW(2)) m_if ();

  iq_mod u_dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .err_seq       (err_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic is_q, input logic [1:0] ch, input int data,
                           input logic exp_err, input string tag);
    int waited;
    @(negedge clk);
    check({tag, "_err_idle"}, int'(err_seq), 0);
    s_if.tvalid = 1'b1;
    s_if.tuser  = {is_q, ch};
    s_if.tdata  = 24'(data);
    waited = 0;
    while (!s_if.tready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_accept"}, int'(s_if.tready), 1);
    @(posedge clk);
    @(negedge clk);
    s_if.tvalid = 1'b0;
    check({tag, "_err"}, int'(err_seq), int'(exp_err));
  endtask

  task automatic send_pair(input logic [1:0] ch, input int i_val, input int q_val,
                           input string tag);
    send_beat(1'b0, ch, i_val, 1'b0, {tag, "_i"});
    send_beat(1'b1, ch, q_val, 1'b0, {tag, "_q"});
  endtask

  // Called on the negedge right after the Q-beat handshake, m_if.tready high.
  task automatic recv(input int exp_data, input int exp_user, input string tag);
    int l;
    l = 0;
    while (!m_if.tvalid && l < 20) begin
      @(negedge clk);
      l++;
    end
    check({tag, "_lat"}, l, 2);
    check({tag, "_data"}, $signed(m_if.tdata), exp_data);
    check({tag, "_user"}, int'(m_if.tuser), exp_user);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld_drop"}, int'(m_if.tvalid), 0);
  endtask

  task automatic expect_idle(input int n, input string tag);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (m_if.tvalid) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  initial begin
    rst         = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    m_if.tready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_tvalid", int'(m_if.tvalid), 0);
    check("rst_tdata", $signed(m_if.tdata), 0);
    check("rst_tuser", int'(m_if.tuser), 0);
    check("rst_err", int'(err_seq), 0);
    check("rst_tready", int'(s_if.tready), 0);
    rst = 1'b0;
    #1;
    check("post_rst_tready", int'(s_if.tready), 1);

    // 1: ch0 full-scale I, phases 0 and 1
    send_pair(2'd0, 8388607, 0, "t1a");
    recv(0, 0, "t1a");
    send_pair(2'd0, 8388607, 0, "t1b");
    recv(3989019, 0, "t1b");

    // 2: Q-only on fresh channels (phase 0)
    send_pair(2'd1, 0, 8388607, "t2a");
    recv(4194303, 1, "t2a");
    send_pair(2'd2, 0, -8388608, "t2b");
    recv(-4194304, 2, "t2b");

    // 3: ch0 phases 2,3; ch3 independent at phase 0
    send_pair(2'd0, 8388607, 0, "t3a");
    recv(2465349, 0, "t3a");
    send_pair(2'd0, 8388607, 0, "t3b");
    recv(-2465351, 0, "t3b");
    send_pair(2'd3, 8388607, 0, "t3c");
    recv(0, 3, "t3c");

    // 4: back-pressure on ch0 phase 4, then wrap to phase 0
    m_if.tready = 1'b0;
    send_pair(2'd0, 8388607, 0, "t4");
    lat = 0;
    while (!m_if.tvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t4_lat", lat, 2);
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_data", $signed(m_if.tdata), -3989021);
      check("t4_hold_user", int'(m_if.tuser), 0);
      check("t4_hold_vld", int'(m_if.tvalid), 1);
      check("t4_hold_sready", int'(s_if.tready), 0);
      @(negedge clk);
    end
    m_if.tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_vld_drop", int'(m_if.tvalid), 0);
    send_pair(2'd0, 8388607, 0, "t4_wrap");
    recv(0, 0, "t4_wrap");

    // 5: sequencing errors
    send_beat(1'b1, 2'd0, 5000, 1'b1, "t5_qfirst");
    expect_idle(6, "t5_qfirst_noout");
    send_beat(1'b0, 2'd0, 123456, 1'b0, "t5_rs_i0");
    send_beat(1'b0, 2'd0, 8388607, 1'b1, "t5_rs_i1");
    send_beat(1'b1, 2'd0, 0, 1'b0, "t5_rs_q");
    recv(3989019, 0, "t5_rs");
    send_beat(1'b0, 2'd0, 8388607, 1'b0, "t5_mm_i");
    send_beat(1'b1, 2'd2, 77, 1'b1, "t5_mm_q");
    expect_idle(6, "t5_mm_noout");
    send_pair(2'd2, 0, 8388607, "t5_ch2");
    recv(1296110, 2, "t5_ch2");
    send_pair(2'd0, 8388607, 0, "t5_ch0");
    recv(2465349, 0, "t5_ch0");

    // 6: reset while in the sum stage
    send_beat(1'b0, 2'd1, 0, 1'b0, "t6_i");
    send_beat(1'b1, 2'd1, 8388607, 1'b0, "t6_q");
    @(negedge clk);
    check("t6_sum_vld", int'(m_if.tvalid), 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_vld", int'(m_if.tvalid), 0);
    check("t6_rst_data", $signed(m_if.tdata), 0);
    check("t6_rst_user", int'(m_if.tuser), 0);
    check("t6_rst_err", int'(err_seq), 0);
    check("t6_rst_sready", int'(s_if.tready), 0);
    rst = 1'b0;
    #1;
    check("t6_rel_sready", int'(s_if.tready), 1);
    send_pair(2'd1, 0, 8388607, "t6_ch1");
    recv(4194303, 1, "t6_ch1");
    send_pair(2'd2, 0, -8388608, "t6_ch2");
    recv(-4194304, 2, "t6_ch2");
    send_pair(2'd0, 8388607, 0, "t6_ch0");
    recv(0, 0, "t6_ch0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
